// File: rtl/mbist_pkg.sv
// March C- BIST shared definitions: FSM states, element table, op codes.
package mbist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_M0, ST_M1, ST_M2, ST_M3,
    ST_M4, ST_M5, ST_DRAIN, ST_DONE
  } state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
  localparam int DRAIN_CYCLES = 3;

  typedef struct packed {
    logic down;
    logic two;
    logic op0;
    logic pol0;
    logic op1;
    logic pol1;
  } elem_t;

  function automatic elem_t march_elem(input state_e s);
    elem_t e;
    unique case (s)
      ST_M0: e = '{1'b0, 1'b0, OP_WR, 1'b0, OP_RD, 1'b0};
      ST_M1: e = '{1'b0, 1'b1, OP_RD, 1'b0, OP_WR, 1'b1};
      ST_M2: e = '{1'b0, 1'b1, OP_RD, 1'b1, OP_WR, 1'b0};
      ST_M3: e = '{1'b1, 1'b1, OP_RD, 1'b0, OP_WR, 1'b1};
      ST_M4: e = '{1'b1, 1'b1, OP_RD, 1'b1, OP_WR, 1'b0};
      ST_M5: e = '{1'b1, 1'b0, OP_RD, 1'b0, OP_RD, 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

  // Encoding places M0..M5, DRAIN consecutively.
  function automatic state_e next_state(input state_e s);
    return state_e'(s + 4'd1);
  endfunction

endpackage

// File: rtl/mbist_resp_cmp.sv
// March C- read checker: expected-data delay line, comparator,
// saturating fail counter and first-failure capture.
module mbist_resp_cmp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FAIL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  vld_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  fail_o,
  output logic [FAIL_CNT_W-1:0] cnt_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic                  s2_vld_q, s3_vld_q;
  logic [ADDR_WIDTH-1:0] s2_addr_q, s3_addr_q;
  logic [DATA_WIDTH-1:0] s2_exp_q, s3_exp_q;
  logic                  fail_q;
  logic [FAIL_CNT_W-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] faddr_q;
  logic [DATA_WIDTH-1:0] frd_q;
  logic                  miss;

  assign miss = s3_vld_q && (rdata_i != s3_exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s3_addr_q <= '0;
      s2_exp_q  <= '0;
      s3_exp_q  <= '0;
    end else begin
      s2_vld_q  <= vld_i;
      s3_vld_q  <= s2_vld_q;
      s2_addr_q <= addr_i;
      s3_addr_q <= s2_addr_q;
      s2_exp_q  <= exp_i;
      s3_exp_q  <= s2_exp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      faddr_q <= '0;
      frd_q   <= '0;
    end else if (clr_i) begin
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      faddr_q <= '0;
      frd_q   <= '0;
    end else if (miss) begin
      fail_q <= 1'b1;
      if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
      if (!fail_q) begin
        faddr_q <= s3_addr_q;
        frd_q   <= rdata_i;
      end
    end
  end

  assign fail_o  = fail_q;
  assign cnt_o   = cnt_q;
  assign addr_o  = faddr_q;
  assign rdata_o = frd_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: FSM, address counter, S0/S1 op stages.
// Define MBIST_CHECKERBOARD_EN for a per-address checkerboard background.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CAPACITY   = 255,
  parameter int FAIL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ph_q, ph_d;
  logic [1:0]            drn_q, drn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  s0_vld_q, s0_vld_d;
  logic                  s0_wr_q, s0_wr_d;
  logic [ADDR_WIDTH-1:0] s0_addr_q, s0_addr_d;
  logic [DATA_WIDTH-1:0] s0_data_q, s0_data_d;
  logic                  s1_vld_q, s1_wr_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] d0;
  elem_t                 el, nel;
  logic [ADDR_WIDTH-1:0] last_a;

`ifdef MBIST_CHECKERBOARD_EN
  assign d0 = {(DATA_WIDTH/2){2'b01}} ^ {DATA_WIDTH{addr_q[0]}};
`else
  assign d0 = '0;
`endif

  assign accept = start && !busy_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ph_d      = ph_q;
    drn_d     = drn_q;
    busy_d    = busy_q;
    done_d    = done_q;
    s0_vld_d  = 1'b0;
    s0_wr_d   = OP_RD;
    s0_addr_d = '0;
    s0_data_d = '0;
    el        = march_elem(state_q);
    nel       = '0;
    last_a    = el.down ? '0 : LAST;
    unique case (state_q)
      ST_IDLE: ;
      ST_DONE: begin
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q + 2'd1;
        if (drn_q == 2'(DRAIN_CYCLES - 1)) begin
          drn_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
        s0_vld_d  = 1'b1;
        s0_wr_d   = ph_q ? el.op1 : el.op0;
        s0_addr_d = addr_q;
        s0_data_d = d0 ^ {DATA_WIDTH{ph_q ? el.pol1 : el.pol0}};
        if (el.two && !ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (addr_q == last_a) begin
            state_d = next_state(state_q);
            nel     = march_elem(state_d);
            addr_d  = nel.down ? LAST : '0;
          end else if (el.down) begin
            addr_d = addr_q - 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_M0;
      addr_d  = '0;
      ph_d    = 1'b0;
      drn_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      ph_q      <= 1'b0;
      drn_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s0_vld_q  <= 1'b0;
      s0_wr_q   <= 1'b0;
      s0_addr_q <= '0;
      s0_data_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_wr_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ph_q      <= ph_d;
      drn_q     <= drn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s0_vld_q  <= s0_vld_d;
      s0_wr_q   <= s0_wr_d;
      s0_addr_q <= s0_addr_d;
      s0_data_q <= s0_data_d;
      s1_vld_q  <= s0_vld_q;
      s1_wr_q   <= s0_vld_q & s0_wr_q;
      s1_addr_q <= s0_addr_q;
      s1_data_q <= s0_data_q;
    end
  end

  // Write data leads its strobe by one cycle.
  assign mem_wdata      = s0_data_q;
  assign mem_write_read = s1_wr_q;
  assign mem_address    = s1_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;

  mbist_resp_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .FAIL_CNT_W(FAIL_CNT_W)
  ) u_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .vld_i  (s1_vld_q & ~s1_wr_q),
    .addr_i (s1_addr_q),
    .exp_i  (s1_data_q),
    .rdata_i(mem_rdata),
    .fail_o (fail),
    .cnt_o  (fail_count),
    .addr_o (fail_addr),
    .rdata_o(fail_rdata)
  );

endmodule
